uart_rx_core: RTL and testbench

Parametrised, oversampling UART receiver that replaces the fixed 8-bit RX path. It synchronises the serial line and qualifies start bits with majority-vote sampling. It supports configurable data width, optional parity and 1 or 2 stop bits, and presents each character with per-character error flags through a one-entry valid/ready holding register. It sits between the board RX pin and the character consumer, clocked from CLOCK_50 with no derived clocks.

---
 rtl/uart_rx_core_if.sv | 46 ++++
 rtl/uart_rx_core.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core_if
//  Description : Serial line plus character-side valid/ready holding-register
//                bundle for uart_rx_core. The receiver uses the master modport
//                and the character consumer or board side uses the slave
//                modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
);
  logic                 DataIn;      // asynchronous serial line, idle high
  logic                 ready;       // consumer accepts the held character
  logic [DATA_BITS-1:0] DataOut;     // received character
  logic                 charRX;      // character valid, held until accepted
  logic                 parity_err;  // parity mismatch for the held character
  logic                 frame_err;   // a stop bit was sampled low
  logic                 overrun;     // at least one character was dropped
  logic                 busy;        // receiver is inside a frame

  // Receiver side
  modport master (
    input  DataIn,
    input  ready,
    output DataOut,
    output charRX,
    output parity_err,
    output frame_err,
    output overrun,
    output busy
  );

  // Line driver / character consumer side
  modport slave (
    output DataIn,
    output ready,
    input  DataOut,
    input  charRX,
    input  parity_err,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core
//  Description : Oversampling UART receiver. It synchronises the line, aligns
//                the tick phase to the start edge and takes a 2-of-3 majority
//                vote around mid-bit. It supports 5..9 data bits, optional
//                odd/even parity and 1 or 2 stop bits. Each character goes
//                into a one-entry valid/ready holding register together with
//                its parity, framing and overrun flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
  parameter int TICK_DIV   = 27,  // clock cycles per oversample tick
  parameter int OVERSAMPLE = 16,  // ticks per bit (even, >= 8)
  parameter int DATA_BITS  = 8,   // 5..9, LSB first
  parameter int PARITY     = 0,   // 0 none, 1 odd, 2 even
  parameter int STOP_BITS  = 1    // 1 or 2
) (
  input wire             CLOCK_50,
  input wire             reset,   // synchronous, active low
  uart_rx_core_if.master bus
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OS_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam int MID    = OVERSAMPLE / 2;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [OS_W-1:0]   OS_SAMP0  = OS_W'(MID - 1);
  localparam logic [OS_W-1:0]   OS_SAMP1  = OS_W'(MID);
  localparam logic [OS_W-1:0]   OS_VOTE   = OS_W'(MID + 1);
  localparam logic [OS_W-1:0]   OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                 sync1_q, sync2_q;
  state_t               state_q;
  logic [TICK_W-1:0]    tick_cnt_q;
  logic [OS_W-1:0]      os_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 s0_q, s1_q;   // first two of the three mid-bit samples
  logic                 armed_q;      // line seen high since the last start
  logic                 par_q;        // parity error of the frame in flight
  logic                 frm_q;        // stop-bit error of the frame in flight
  logic                 busy_q;

  logic [DATA_BITS-1:0] data_q;
  logic                 charrx_q, perr_q, ferr_q, ovr_q;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic rx_s;
  logic tick, samp0, samp1, vote_tick, bit_end, vote, start_det;
  logic done_d, ferr_d;

  assign rx_s = sync2_q;

  // Tick strobe, sample points and the majority vote on the third sample
  always_comb begin
    tick      = (tick_cnt_q == TICK_LAST);
    samp0     = tick && (os_cnt_q == OS_SAMP0);
    samp1     = tick && (os_cnt_q == OS_SAMP1);
    vote_tick = tick && (os_cnt_q == OS_VOTE);
    bit_end   = tick && (os_cnt_q == OS_LAST);
    vote      = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
    start_det = (state_q == ST_IDLE) && armed_q && !rx_s;
    done_d    = (state_q == ST_STOP) && vote_tick && (bit_cnt_q == STOP_LAST);
    ferr_d    = frm_q | ~vote;
  end

  // Two-flop synchroniser, idle-high reset so reset does not look like a start
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.DataIn;
      sync2_q <= sync1_q;
    end
  end

  // Receive FSM with tick/oversample/bit counters and the shift register
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      armed_q    <= 1'b1;
      par_q      <= 1'b0;
      frm_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // Free-running tick divider; rezeroed below on a start edge
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;

      if (tick && (state_q != ST_IDLE)) begin
        os_cnt_q <= (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
      end
      if (samp0) s0_q <= rx_s;
      if (samp1) s1_q <= rx_s;

      case (state_q)
        ST_IDLE: begin
          os_cnt_q  <= '0;
          bit_cnt_q <= '0;
          if (start_det) begin
            state_q    <= ST_START;
            tick_cnt_q <= '0;
            armed_q    <= 1'b0;
            par_q      <= 1'b0;
            frm_q      <= 1'b0;
            busy_q     <= 1'b1;
          end else if (rx_s) begin
            armed_q <= 1'b1;
          end
        end

        ST_START: begin
          // A high vote at mid-bit means the edge was noise
          if (vote_tick && vote) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (bit_end) begin
            state_q   <= ST_DATA;
            bit_cnt_q <= '0;
          end
        end

        ST_DATA: begin
          if (vote_tick) begin
            shift_q <= {vote, shift_q[DATA_BITS-1:1]};
          end
          if (bit_end) begin
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          if (vote_tick) begin
            par_q <= (^shift_q) ^ vote ^ PAR_ODD;
          end
          if (bit_end) begin
            state_q   <= ST_STOP;
            bit_cnt_q <= '0;
          end
        end

        ST_STOP: begin
          // Leave on the last stop vote, not the bit end, to absorb baud skew
          if (vote_tick) begin
            if (!vote) frm_q <= 1'b1;
            if (bit_cnt_q == STOP_LAST) begin
              state_q   <= ST_IDLE;
              bit_cnt_q <= '0;
              busy_q    <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // One-entry holding register: load on completion, drop with overrun if full
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      data_q   <= '0;
      charrx_q <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else if (done_d) begin
      if (!charrx_q || bus.ready) begin
        data_q   <= shift_q;
        charrx_q <= 1'b1;
        perr_q   <= par_q;
        ferr_q   <= ferr_d;
        ovr_q    <= 1'b0;
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (bus.ready && charrx_q) begin
      charrx_q <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end
  end

  assign bus.DataOut    = data_q;
  assign bus.charRX     = charrx_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_core
//  Description : Directed and random frames into two receivers, one without
//                parity and one with even parity. Expected characters and
//                flags come from the frame contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

  localparam int TD  = 4;
  localparam int OS  = 16;
  localparam int BIT = TD * OS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_rx_core_if #(.DATA_BITS(8)) if0 ();
  uart_rx_core_if #(.DATA_BITS(8)) if2 ();

  uart_rx_core #(.TICK_DIV(TD), .OVERSAMPLE(OS), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1)) dut0 (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .bus      (if0)
  );

  uart_rx_core #(.TICK_DIV(TD), .OVERSAMPLE(OS), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(1)) dut2 (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .bus      (if2)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } rec_t;

  rec_t q0[$];
  rec_t q2[$];
  int   hi0 = 0;
  bit   busy_seen0 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Record every accepted character and count charRX-high cycles
  always @(negedge clk) begin
    rec_t r;
    if (if0.charRX === 1'b1) hi0++;
    if (if0.busy === 1'b1) busy_seen0 = 1'b1;
    if (if0.charRX === 1'b1 && if0.ready === 1'b1) begin
      r.d = if0.DataOut; r.pe = if0.parity_err; r.fe = if0.frame_err; r.ov = if0.overrun;
      q0.push_back(r);
    end
    if (if2.charRX === 1'b1 && if2.ready === 1'b1) begin
      r.d = if2.DataOut; r.pe = if2.parity_err; r.fe = if2.frame_err; r.ov = if2.overrun;
      q2.push_back(r);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) if0.DataIn = v;
    else            if2.DataIn = v;
  endtask

  task automatic send_frame(input int which, input logic [7:0] d,
                            input bit has_par, input bit pbit, input bit stopv);
    set_line(which, 1'b0);
    step(BIT);
    for (int i = 0; i < 8; i++) begin
      set_line(which, d[i]);
      step(BIT);
    end
    if (has_par) begin
      set_line(which, pbit);
      step(BIT);
    end
    set_line(which, stopv);
    step(BIT);
    set_line(which, 1'b1);
  endtask

  // Exactly one character expected in the chosen queue
  task automatic expect_char(input int which, input string tag, input logic [7:0] d,
                             input logic pe, input logic fe, input logic ov);
    rec_t r;
    int   n;
    n = (which == 0) ? q0.size() : q2.size();
    check({tag, "_count"}, n, 1);
    if (n > 0) begin
      r = (which == 0) ? q0.pop_front() : q2.pop_front();
      check({tag, "_data"}, r.d, d);
      check({tag, "_perr"}, r.pe, pe);
      check({tag, "_ferr"}, r.fe, fe);
      check({tag, "_ovr"},  r.ov, ov);
    end
    if (which == 0) q0.delete();
    else            q2.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  if0.DataOut,    0);
    check({tag, "_chr"},   if0.charRX,     0);
    check({tag, "_perr"},  if0.parity_err, 0);
    check({tag, "_ferr"},  if0.frame_err,  0);
    check({tag, "_ovr"},   if0.overrun,    0);
    check({tag, "_busy"},  if0.busy,       0);
  endtask

  function automatic bit even_par_err(input logic [7:0] d, input bit p);
    return ((($countones(d) + int'(p)) % 2) != 0);
  endfunction

  initial begin
    logic [7:0] b;
    bit         p;
    int         h;

    rst_n      = 1'b0;
    if0.DataIn = 1'b1;
    if0.ready  = 1'b1;
    if2.DataIn = 1'b1;
    if2.ready  = 1'b1;
    step(5);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    step(20);

    // Basic no-parity frame, one-cycle valid pulse
    h = hi0;
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    step(4);
    expect_char(0, "f55", 8'h55, 1'b0, 1'b0, 1'b0);
    check("f55_pulse", hi0 - h, 1);

    // Random no-parity frames
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send_frame(0, b, 1'b0, 1'b0, 1'b1);
      step(4);
      expect_char(0, "rnd0", b, 1'b0, 1'b0, 1'b0);
    end

    // Even parity: good then bad parity bit
    send_frame(2, 8'hA3, 1'b1, 1'b0, 1'b1);
    step(4);
    expect_char(2, "pA3ok", 8'hA3, 1'b0, 1'b0, 1'b0);
    send_frame(2, 8'hA3, 1'b1, 1'b1, 1'b1);
    step(4);
    expect_char(2, "pA3bad", 8'hA3, 1'b1, 1'b0, 1'b0);

    // Random data and parity bits against the even-parity rule
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      p = 1'($urandom_range(1, 0));
      send_frame(2, b, 1'b1, p, 1'b1);
      step(4);
      expect_char(2, "rndp", b, even_par_err(b, p), 1'b0, 1'b0);
    end

    // Short glitch is rejected as a false start
    busy_seen0 = 1'b0;
    h = hi0;
    set_line(0, 1'b0);
    step(10);
    set_line(0, 1'b1);
    step(3 * BIT);
    check("glitch_busy_seen", busy_seen0, 1);
    check("glitch_busy_end", if0.busy, 0);
    check("glitch_nochar", hi0 - h, 0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    step(4);
    expect_char(0, "f3C", 8'h3C, 1'b0, 1'b0, 1'b0);

    // Overrun: second character dropped while the first is held
    if0.ready = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    step(4);
    check("ovr_data", if0.DataOut, 8'h11);
    check("ovr_chr", if0.charRX, 1);
    check("ovr_flag", if0.overrun, 1);
    check("ovr_noacc", q0.size(), 0);
    if0.ready = 1'b1;
    step(1);
    if0.ready = 1'b0;
    step(2);
    check("acc_chr", if0.charRX, 0);
    check("acc_ovr", if0.overrun, 0);
    check("acc_perr", if0.parity_err, 0);
    check("acc_ferr", if0.frame_err, 0);
    check("acc_data_kept", if0.DataOut, 8'h11);
    expect_char(0, "ovr_acc", 8'h11, 1'b0, 1'b0, 1'b1);
    h = hi0;
    step(100);
    check("acc_no_more", hi0 - h, 0);
    if0.ready = 1'b1;

    // Break: line low for two frame times yields exactly one framed zero
    h = hi0;
    set_line(0, 1'b0);
    step(20 * BIT);
    set_line(0, 1'b1);
    step(2 * BIT);
    check("brk_once", hi0 - h, 1);
    expect_char(0, "brk", 8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
    step(4);
    expect_char(0, "f81", 8'h81, 1'b0, 1'b0, 1'b0);

    // Reset pulse in the middle of data bit 3 aborts the frame (0xF8)
    h = hi0;
    b = 8'hF8;
    set_line(0, 1'b0);
    step(BIT);
    for (int i = 0; i < 3; i++) begin
      set_line(0, b[i]);
      step(BIT);
    end
    set_line(0, b[3]);
    step(BIT / 2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check_reset_outputs("midrst");
    step(BIT / 2);
    for (int i = 4; i < 8; i++) begin
      set_line(0, b[i]);
      step(BIT);
    end
    set_line(0, 1'b1);
    step(3 * BIT);
    check("midrst_nochar", hi0 - h, 0);
    check("midrst_q", q0.size(), 0);
    send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1);
    step(4);
    expect_char(0, "fF0", 8'hF0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
